multi_channel_capture_timer: RTL and testbench
==============================================

# multi_channel_capture_timer

Parametrised multi-channel capture timer and the next generation of the single-channel capture FSM. A shared free-running counter of configurable width is timestamped independently by NUM_CH capture inputs. The block supports one-shot and continuous capture modes, an explicit stop, per-channel overrun flags and a sticky counter-overflow flag. It sits between the synchronised external trigger inputs and the register interface.

## Interface
- CNT_W, 32, counter and captured-value width (2..64)
- NUM_CH, 4, number of capture channels (1..16)
- clk_i  in  1  clock
- rst_an_i  in  1  reset, asynchronous, active-low
- start_i  in  1  level, already synchronised; rising edge starts/restarts counting
- stop_i  in  1  level; rising edge freezes counting
- clear_i  in  1  level; rising edge returns block to idle and clears all results
- capture_i  in  NUM_CH  levels; rising edge on bit k captures into channel k
- mode_i  in  1  0 = one-shot, 1 = continuous; sampled each cycle
- counter_o  out  CNT_W  current counter value
- captured_o  out  NUM_CH*CNT_W  channel k in bits [k*CNT_W +: CNT_W]
- valid_o  out  NUM_CH  channel k holds a capture since last start/clear
- overrun_o  out  NUM_CH  sticky: capture edge arrived while valid_o[k] was already 1
- overflow_o  out  1  sticky: counter wrapped while counting
- state_o  out  2  FSM state

## Operation
- Edge detection: each level input has a previous-value register (reset 0). rise = in & ~prev. A level already high at the first clock after reset counts as a rising edge.
- States: ST_IDLE=0, ST_COUNTING=1, ST_DONE=2. Encoding 3 is unreachable and recovers to ST_IDLE.
- Priority each cycle: clear rise > start rise > stop rise / captures / auto-done.
- Clear rise, any state: state to IDLE. counter, all captured, valid, overrun and overflow to 0.
- IDLE: counter held at 0. Start rise goes to COUNTING with counter 0.
- COUNTING: counter += 1 per cycle, modulo 2^CNT_W. Wrap from all-ones to 0 sets overflow_o.
  - Start rise restarts: counter 0, valid and overrun cleared, captured values retained, overflow retained.
  - Stop rise goes to DONE. The counter does not increment on that edge.
- Capture, COUNTING only; captures in IDLE/DONE are ignored and have no side effects. On rise of capture_i[k]:
  - valid=0: captured[k] <= counter_o, valid[k] <= 1.
  - valid=1, one-shot: value kept, overrun[k] <= 1.
  - valid=1, continuous: captured[k] <= counter_o, overrun[k] <= 1.
- Auto-done: in one-shot mode, when all valid bits are 1, the FSM moves to DONE on the next edge. Continuous mode never auto-dones.
- DONE: counter frozen. Start rise goes to COUNTING as from IDLE (counter 0, valid/overrun cleared).
- Simultaneous events:
  - Capture and stop on the same edge: capture taken, then DONE.
  - Capture and start on the same edge while COUNTING: capture ignored.
  - Capture and counter wrap on the same edge: captures the all-ones value, overflow set.
  - Multiple channels on the same edge: each captures the same value.

## Timing
- All outputs registered. Reset value of every output is 0 (state_o = ST_IDLE).
- Rising input first sampled high at edge t takes effect at edge t. The result is visible after t.
- Start at edge t: counter_o = k after edge t+k.
- Captured value = counter_o as visible in the cycle before edge t, i.e. pre-increment.
- Auto-done: DONE visible one cycle after the edge that set the last valid bit.
- Reset mid-operation: asynchronous, immediately forces all registers, including edge-detect history, to 0.

## Structure
- Package capture_timer_pkg holds the ST_* state localparams, the state width (2), and the mode encodings MODE_ONESHOT=0 and MODE_CONT=1.
- Sub-module capture_channel (parameter CNT_W), instantiated NUM_CH times via generate:
  - contains the edge register, captured register, valid and overrun.
  - inputs: counting-enable, restart, clear, mode, counter.
- Top level holds the start/stop/clear edge detectors, the counter, overflow, and the FSM.

## Test plan
- Start at edge 1, capture_i[0] rise at edge 11 -> captured ch0 = 9, valid_o = 0001, state COUNTING; stop at edge 20 -> DONE, counter_o frozen at 18.
- One-shot, all 4 channels captured at edges 5/6/7/8 -> captured 3/4/5/6, DONE visible after edge 9; further edges ignored.
- One-shot double capture ch1 -> first value retained, overrun_o[1] = 1. Continuous mode -> value updated, overrun set.
- CNT_W=4: start, run 16 cycles -> counter 15 -> 0, overflow_o = 1. Capture on the wrap edge -> 15.
- Clear and capture same edge -> all outputs 0, IDLE. Start and capture same edge while COUNTING -> counter 0, valid 0.
- Assert rst_an_i mid-count between clock edges -> all outputs 0 immediately. A start held high through release counts as a rising edge at the first clock.

Source files
------------

// File: rtl/capture_timer_pkg.sv
// Shared encodings for the multi-channel capture timer: FSM states and capture modes.
package capture_timer_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE     = 2'd0;
  localparam logic [ST_W-1:0] ST_COUNTING = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE     = 2'd2;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/capture_channel.sv
// One capture channel: edge detector on its trigger, timestamp register, valid and overrun flags.
module capture_channel
  import capture_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             capture_i,
  input  logic             cnt_en_i,
  input  logic             restart_i,
  input  logic             clear_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] counter_i,
  output logic [CNT_W-1:0] captured_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic             cap_prev_q, cap_prev_d;
  logic [CNT_W-1:0] captured_q, captured_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             cap_rise;

  assign cap_rise = capture_i & ~cap_prev_q;

  always_comb begin
    cap_prev_d = capture_i;
    captured_d = captured_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    if (clear_i) begin
      captured_d = '0;
      valid_d    = 1'b0;
      overrun_d  = 1'b0;
    end else if (restart_i) begin
      // Restart keeps the last timestamp but forgets that it was taken.
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else if (cnt_en_i && cap_rise) begin
      if (!valid_q) begin
        captured_d = counter_i;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (mode_i == MODE_CONT) captured_d = counter_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      cap_prev_q <= 1'b0;
      captured_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      cap_prev_q <= cap_prev_d;
      captured_q <= captured_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign captured_o = captured_q;
  assign valid_o    = valid_q;
  assign overrun_o  = overrun_q;

endmodule

// File: rtl/multi_channel_capture_timer.sv
// Free-running counter with start/stop/clear control timestamped by NUM_CH capture channels.
module multi_channel_capture_timer
  import capture_timer_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_an_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic                    clear_i,
  input  logic [NUM_CH-1:0]       capture_i,
  input  logic                    mode_i,
  output logic [CNT_W-1:0]        counter_o,
  output logic [NUM_CH*CNT_W-1:0] captured_o,
  output logic [NUM_CH-1:0]       valid_o,
  output logic [NUM_CH-1:0]       overrun_o,
  output logic                    overflow_o,
  output logic [ST_W-1:0]         state_o
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             overflow_q, overflow_d;
  logic             start_prev_q, start_prev_d;
  logic             stop_prev_q, stop_prev_d;
  logic             clear_prev_q, clear_prev_d;
  logic             start_rise, stop_rise, clear_rise;
  logic             cap_en_c, restart_c;
  logic             all_valid;

  assign start_rise = start_i & ~start_prev_q;
  assign stop_rise  = stop_i  & ~stop_prev_q;
  assign clear_rise = clear_i & ~clear_prev_q;
  assign all_valid  = &valid_o;

  always_comb begin
    start_prev_d = start_i;
    stop_prev_d  = stop_i;
    clear_prev_d = clear_i;
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state: clear beats start, start beats stop and auto-done.
  always_comb begin
    state_d = state_q;
    if (clear_rise) begin
      state_d = ST_IDLE;
    end else if (start_rise) begin
      state_d = ST_COUNTING;
    end else begin
      unique case (state_q)
        ST_IDLE:     state_d = ST_IDLE;
        ST_COUNTING: begin
          if (stop_rise) state_d = ST_DONE;
          else if ((mode_i == MODE_ONESHOT) && all_valid) state_d = ST_DONE;
        end
        ST_DONE:     state_d = ST_DONE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    counter_d  = counter_q;
    overflow_d = overflow_q;
    cap_en_c   = 1'b0;
    restart_c  = 1'b0;
    if (clear_rise) begin
      counter_d  = '0;
      overflow_d = 1'b0;
    end else if (start_rise) begin
      counter_d = '0;
      restart_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_COUNTING: begin
          cap_en_c = 1'b1;
          // The stop edge itself does not advance the counter.
          if (!stop_rise) begin
            counter_d = counter_q + CNT_W'(1);
            if (&counter_q) overflow_d = 1'b1;
          end
        end
        ST_DONE: counter_d = counter_q;
        default: counter_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      counter_q    <= '0;
      overflow_q   <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      overflow_q   <= overflow_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      clear_prev_q <= clear_prev_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    capture_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_an_i   (rst_an_i),
      .capture_i  (capture_i[k]),
      .cnt_en_i   (cap_en_c),
      .restart_i  (restart_c),
      .clear_i    (clear_rise),
      .mode_i     (mode_i),
      .counter_i  (counter_q),
      .captured_o (captured_o[k*CNT_W +: CNT_W]),
      .valid_o    (valid_o[k]),
      .overrun_o  (overrun_o[k])
    );
  end

  assign counter_o  = counter_q;
  assign overflow_o = overflow_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multi_channel_capture_timer.sv
// Bench for multi_channel_capture_timer: 32-bit and 4-bit instances on shared stimulus vs a cycle model.
module tb_multi_channel_capture_timer;

  logic clk;
  logic rst_an;
  logic start, stop, clr, mode;
  logic [3:0] cap;

  logic [31:0]  cnt32;
  logic [127:0] capd32;
  logic [3:0]   val32, ovr32;
  logic         ovf32;
  logic [1:0]   st32;

  logic [3:0]  cnt4;
  logic [15:0] capd4;
  logic [3:0]  val4, ovr4;
  logic        ovf4;
  logic [1:0]  st4;

  int tests_run;
  int tests_failed;

  // Reference model: index 0 is the 32-bit instance, index 1 the 4-bit one.
  int          m_state;
  logic [63:0] m_cnt [2];
  logic        m_ovf [2];
  logic [63:0] m_cap [2][4];
  logic [3:0]  m_valid, m_ovr;
  logic        m_pstart, m_pstop, m_pclr;
  logic [3:0]  m_pcap;

  multi_channel_capture_timer #(.CNT_W(32), .NUM_CH(4)) dut (
    .clk_i(clk), .rst_an_i(rst_an), .start_i(start), .stop_i(stop), .clear_i(clr),
    .capture_i(cap), .mode_i(mode), .counter_o(cnt32), .captured_o(capd32),
    .valid_o(val32), .overrun_o(ovr32), .overflow_o(ovf32), .state_o(st32)
  );

  multi_channel_capture_timer #(.CNT_W(4), .NUM_CH(4)) dut4 (
    .clk_i(clk), .rst_an_i(rst_an), .start_i(start), .stop_i(stop), .clear_i(clr),
    .capture_i(cap), .mode_i(mode), .counter_o(cnt4), .captured_o(capd4),
    .valid_o(val4), .overrun_o(ovr4), .overflow_o(ovf4), .state_o(st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mask_of(int i);
    return (i == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = '0;
      m_ovf[i] = 1'b0;
      for (int k = 0; k < 4; k++) m_cap[i][k] = '0;
    end
    m_valid = '0; m_ovr = '0;
    m_pstart = 1'b0; m_pstop = 1'b0; m_pclr = 1'b0; m_pcap = '0;
  endtask

  task automatic model_step();
    logic rs, rp, rc, allv;
    logic [3:0] rcap;
    rs = start & ~m_pstart;
    rp = stop & ~m_pstop;
    rc = clr & ~m_pclr;
    rcap = cap & ~m_pcap;
    allv = (m_valid == 4'hF);
    if (rc) begin
      model_reset();
    end else if (rs) begin
      m_state = 1;
      m_cnt[0] = '0; m_cnt[1] = '0;
      m_valid = '0; m_ovr = '0;
    end else if (m_state == 1) begin
      for (int k = 0; k < 4; k++) begin
        if (rcap[k]) begin
          if (!m_valid[k]) begin
            m_cap[0][k] = m_cnt[0]; m_cap[1][k] = m_cnt[1];
            m_valid[k] = 1'b1;
          end else begin
            m_ovr[k] = 1'b1;
            if (mode) begin m_cap[0][k] = m_cnt[0]; m_cap[1][k] = m_cnt[1]; end
          end
        end
      end
      if (rp) begin
        m_state = 2;
      end else begin
        if (allv && !mode) m_state = 2;
        for (int i = 0; i < 2; i++) begin
          if (m_cnt[i] == mask_of(i)) begin m_cnt[i] = '0; m_ovf[i] = 1'b1; end
          else m_cnt[i] = m_cnt[i] + 64'd1;
        end
      end
    end
    m_pstart = start; m_pstop = stop; m_pclr = clr; m_pcap = cap;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic go_idle();
    start = 0; stop = 0; cap = '0; clr = 1;
    tick();
    clr = 0;
    tick();
  endtask

  task automatic test_reset();
    rst_an = 0; start = 0; stop = 0; clr = 0; cap = '0; mode = 0;
    model_reset();
    @(negedge clk);
    tests_run++;
    if ({cnt32, capd32, val32, ovr32, ovf32, st32} !== '0) begin
      tests_failed++; $display("FAIL reset32: got cnt=%0d st=%0d val=%b expected all 0", cnt32, st32, val32);
    end
    tests_run++;
    if ({cnt4, capd4, val4, ovr4, ovf4, st4} !== '0) begin
      tests_failed++; $display("FAIL reset4: got cnt=%0d st=%0d val=%b expected all 0", cnt4, st4, val4);
    end
    #2 rst_an = 1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    go_idle();
    start = 1; tick(); start = 0;
    repeat (9) tick();
    cap = 4'b0001; tick();
    tests_run++;
    if (capd32[31:0] !== 32'd9) begin tests_failed++; $display("FAIL basic_cap: got %0d expected 9", capd32[31:0]); end
    tests_run++;
    if (val32 !== 4'b0001) begin tests_failed++; $display("FAIL basic_valid: got %b expected 0001", val32); end
    tests_run++;
    if (st32 !== 2'd1) begin tests_failed++; $display("FAIL basic_state: got %0d expected 1", st32); end
    cap = '0;
    repeat (8) tick();
    stop = 1; tick();
    tests_run++;
    if (st32 !== 2'd2) begin tests_failed++; $display("FAIL stop_state: got %0d expected 2", st32); end
    tests_run++;
    if (cnt32 !== 32'd18) begin tests_failed++; $display("FAIL stop_cnt: got %0d expected 18", cnt32); end
    stop = 0;
    repeat (3) tick();
    tests_run++;
    if (cnt32 !== 32'd18) begin tests_failed++; $display("FAIL frozen_cnt: got %0d expected 18", cnt32); end
    tests_run++;
    if (cnt4 !== 4'd2 || ovf4 !== 1'b1) begin
      tests_failed++; $display("FAIL frozen_cnt4: got %0d/%0d expected 2/1", cnt4, ovf4);
    end
  endtask

  task automatic test_oneshot_all();
    go_idle();
    mode = 0;
    start = 1; tick(); start = 0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin cap[k] = 1'b1; tick(); end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (capd32[k*32 +: 32] !== 32'(k + 3) || capd4[k*4 +: 4] !== 4'(k + 3)) begin
        tests_failed++;
        $display("FAIL oneshot_cap%0d: got %0d/%0d expected %0d", k, capd32[k*32 +: 32], capd4[k*4 +: 4], k + 3);
      end
    end
    tests_run++;
    if (val32 !== 4'hF || st32 !== 2'd1) begin
      tests_failed++; $display("FAIL oneshot_pre: got val=%b st=%0d expected 1111/1", val32, st32);
    end
    tick();
    tests_run++;
    if (st32 !== 2'd2 || st4 !== 2'd2) begin
      tests_failed++; $display("FAIL autodone: got %0d/%0d expected 2", st32, st4);
    end
    cap = '0; tick();
    cap = 4'hF; tick();
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (capd32[k*32 +: 32] !== 32'(k + 3)) begin
        tests_failed++; $display("FAIL done_ignore%0d: got %0d expected %0d", k, capd32[k*32 +: 32], k + 3);
      end
    end
    tests_run++;
    if (ovr32 !== 4'h0) begin tests_failed++; $display("FAIL done_ovr: got %b expected 0000", ovr32); end
    cap = '0; tick();
  endtask

  task automatic test_overrun();
    go_idle();
    mode = 0;
    start = 1; tick(); start = 0; tick();
    cap[1] = 1; tick(); cap = '0; tick(); cap[1] = 1; tick();
    tests_run++;
    if (capd32[63:32] !== 32'd1 || ovr32 !== 4'b0010 || val32 !== 4'b0010) begin
      tests_failed++; $display("FAIL oneshot_ovr: got cap=%0d ovr=%b val=%b expected 1/0010/0010", capd32[63:32], ovr32, val32);
    end
    cap = '0; mode = 1;
    start = 1; tick();
    tests_run++;
    if (capd32[63:32] !== 32'd1 || ovr32 !== 4'b0 || val32 !== 4'b0) begin
      tests_failed++; $display("FAIL restart_keep: got cap=%0d ovr=%b val=%b expected 1/0000/0000", capd32[63:32], ovr32, val32);
    end
    start = 0; tick();
    cap[1] = 1; tick(); cap = '0; tick(); cap[1] = 1; tick();
    tests_run++;
    if (capd32[63:32] !== 32'd3 || ovr32 !== 4'b0010) begin
      tests_failed++; $display("FAIL cont_ovr: got cap=%0d ovr=%b expected 3/0010", capd32[63:32], ovr32);
    end
    cap = '0; mode = 0; tick();
  endtask

  task automatic test_wrap();
    go_idle();
    start = 1; tick(); start = 0;
    repeat (15) tick();
    tests_run++;
    if (cnt4 !== 4'd15 || ovf4 !== 1'b0) begin
      tests_failed++; $display("FAIL pre_wrap: got %0d/%0d expected 15/0", cnt4, ovf4);
    end
    cap[2] = 1; tick();
    tests_run++;
    if (cnt4 !== 4'd0 || ovf4 !== 1'b1 || capd4[11:8] !== 4'd15) begin
      tests_failed++; $display("FAIL wrap4: got cnt=%0d ovf=%0d cap=%0d expected 0/1/15", cnt4, ovf4, capd4[11:8]);
    end
    tests_run++;
    if (cnt32 !== 32'd16 || ovf32 !== 1'b0 || capd32[95:64] !== 32'd15) begin
      tests_failed++; $display("FAIL nowrap32: got cnt=%0d ovf=%0d cap=%0d expected 16/0/15", cnt32, ovf32, capd32[95:64]);
    end
    cap = '0; tick();
  endtask

  task automatic test_clear_capture();
    clr = 1; cap[0] = 1; tick();
    tests_run++;
    if ({cnt32, capd32, val32, ovr32, ovf32, st32} !== '0 || {cnt4, capd4, val4, ovr4, ovf4, st4} !== '0) begin
      tests_failed++; $display("FAIL clear_cap: got cnt=%0d st=%0d val=%b ovf4=%0d expected all 0", cnt32, st32, val32, ovf4);
    end
    clr = 0; cap = '0; tick();
    start = 1; tick(); start = 0;
    repeat (3) tick();
    start = 1; cap[0] = 1; tick();
    tests_run++;
    if (cnt32 !== 32'd0 || val32 !== 4'b0 || st32 !== 2'd1) begin
      tests_failed++; $display("FAIL start_cap: got cnt=%0d val=%b st=%0d expected 0/0000/1", cnt32, val32, st32);
    end
    start = 0; cap = '0; tick();
  endtask

  task automatic test_async_reset();
    repeat (4) tick();
    start = 1;
    #2 rst_an = 0;
    #1;
    model_reset();
    tests_run++;
    if ({cnt32, capd32, val32, ovr32, ovf32, st32} !== '0 || {cnt4, capd4, val4, ovr4, ovf4, st4} !== '0) begin
      tests_failed++; $display("FAIL async_rst: got cnt=%0d st=%0d expected all 0", cnt32, st32);
    end
    @(posedge clk);
    @(negedge clk);
    #2 rst_an = 1;
    tick();
    tests_run++;
    if (st32 !== 2'd1 || cnt32 !== 32'd0) begin
      tests_failed++; $display("FAIL start_thru_rst: got st=%0d cnt=%0d expected 1/0", st32, cnt32);
    end
    start = 0; tick();
    tests_run++;
    if (cnt32 !== 32'd1) begin tests_failed++; $display("FAIL post_rst_cnt: got %0d expected 1", cnt32); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      clr   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 24) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      cap   = cap ^ 4'($urandom() & $urandom());
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      tick();
      tests_run++;
      if (cnt32 !== m_cnt[0][31:0] || cnt4 !== m_cnt[1][3:0]) begin
        tests_failed++; $display("FAIL rand_cnt @%0d: got %0d/%0d expected %0d/%0d", n, cnt32, cnt4, m_cnt[0], m_cnt[1]);
      end
      tests_run++;
      if (st32 !== 2'(m_state) || st4 !== 2'(m_state)) begin
        tests_failed++; $display("FAIL rand_state @%0d: got %0d/%0d expected %0d", n, st32, st4, m_state);
      end
      tests_run++;
      if (val32 !== m_valid || val4 !== m_valid || ovr32 !== m_ovr || ovr4 !== m_ovr) begin
        tests_failed++; $display("FAIL rand_flags @%0d: got val=%b ovr=%b expected %b/%b", n, val32, ovr32, m_valid, m_ovr);
      end
      tests_run++;
      if (ovf32 !== m_ovf[0] || ovf4 !== m_ovf[1]) begin
        tests_failed++; $display("FAIL rand_ovf @%0d: got %0d/%0d expected %0d/%0d", n, ovf32, ovf4, m_ovf[0], m_ovf[1]);
      end
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (capd32[k*32 +: 32] !== m_cap[0][k][31:0] || capd4[k*4 +: 4] !== m_cap[1][k][3:0]) begin
          tests_failed++;
          $display("FAIL rand_cap%0d @%0d: got %0d/%0d expected %0d/%0d", k, n,
                   capd32[k*32 +: 32], capd4[k*4 +: 4], m_cap[0][k], m_cap[1][k]);
        end
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_oneshot_all();
    test_overrun();
    test_wrap();
    test_clear_capture();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
